// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and state encodings plus instruction-word field positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_MOVF = 4'h0,
    OP_AND  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_IOR  = 4'h4,
    OP_INC  = 4'h5,
    OP_DEC  = 4'h6,
    OP_XOR  = 4'h7,
    OP_NOP  = 4'h8,
    OP_COM  = 4'h9,
    OP_RLF  = 4'hA,
    OP_RRF  = 4'hB,
    OP_BCF  = 4'hC,
    OP_BSF  = 4'hD,
    OP_SWAP = 4'hE,
    OP_ILL  = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  // instr_word field positions
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int BIT_MSB  = 11;
  localparam int BIT_LSB  = 9;
  localparam int D_POS    = 8;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 0;

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: classifies an opcode (operand read needed, carry update, nop, illegal).
// Latency: purely combinational.
// Backpressure: none.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output logic       needs_read,
  output logic       updates_carry,
  output logic       is_nop,
  output logic       illegal
);

  // nop and illegal skip the operand read and never touch W, flags or the register file
  always_comb begin
    is_nop        = (op == OP_NOP);
    illegal       = (op == OP_ILL);
    needs_read    = !((op == OP_NOP) || (op == OP_ILL));
    updates_carry = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: updates_carry = 1'b1;
      default:                        updates_carry = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE/READ/EXEC/WB sequencer driving an external 8-bit ALU and register file.
// Latency: accept at cycle 0, done at cycle 3 (nop/illegal at cycle 1).
// Backpressure: instr_ready only in IDLE, plus WB when ALU_SEQ_OVERLAP_EN is defined.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr_word,
  output logic [7:0]  rf_addr,
  output logic        rf_re,
  input  logic [7:0]  rf_rdata,
  output logic        rf_we,
  output logic [7:0]  rf_wdata,
  output logic [3:0]  alu_op,
  output logic [2:0]  alu_bit,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry,
  output logic [7:0]  w_out,
  output logic        flag_z,
  output logic        flag_c,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e      state;
  logic [3:0]  op_q;
  logic [2:0]  bit_q;
  logic        d_q;
  logic [7:0]  addr_q;
  logic        rd_q;
  logic        upd_c_q;
  logic [7:0]  opnd_q;
  logic [7:0]  res_q;
  logic        carry_q;

  logic        dec_needs_read;
  logic        dec_updates_carry;
  logic        dec_is_nop;
  logic        dec_illegal;
  logic        accept;

  // decode the incoming word so the accept cycle can pick READ or WB directly
  alu_seq_decode u_decode (
    .op            (instr_word[OP_MSB:OP_LSB]),
    .needs_read    (dec_needs_read),
    .updates_carry (dec_updates_carry),
    .is_nop        (dec_is_nop),
    .illegal       (dec_illegal)
  );

`ifdef ALU_SEQ_OVERLAP_EN
  // WB only consumes already-captured result/address, so the next word can be latched there
  assign instr_ready = (state == S_IDLE) || (state == S_WB);
`else
  assign instr_ready = (state == S_IDLE);
`endif

  assign accept   = instr_valid && instr_ready;
  assign busy     = (state != S_IDLE);
  assign rf_addr  = addr_q;
  assign rf_wdata = res_q;
  assign alu_a    = w_out;
  assign alu_op   = (state == S_IDLE) ? 4'(OP_NOP) : op_q;
  assign alu_bit  = bit_q;
  // read data only arrives during EXEC, so the ALU sees it directly then and the held copy afterwards
  assign alu_b    = (state == S_EXEC) ? rf_rdata : opnd_q;

  // sequencer FSM with registered strobes; an accept overrides the WB->IDLE return
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      op_q    <= 4'(OP_NOP);
      bit_q   <= 3'd0;
      d_q     <= 1'b0;
      addr_q  <= 8'h00;
      rd_q    <= 1'b0;
      upd_c_q <= 1'b0;
      opnd_q  <= 8'h00;
      res_q   <= 8'h00;
      carry_q <= 1'b0;
      w_out   <= 8'h00;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      rf_re   <= 1'b0;
      rf_we   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      rf_re <= 1'b0;
      rf_we <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: state <= S_IDLE;
        S_READ: state <= S_EXEC;
        S_EXEC: begin
          opnd_q  <= rf_rdata;
          res_q   <= alu_result;
          carry_q <= alu_carry;
          rf_we   <= d_q;
          done    <= 1'b1;
          state   <= S_WB;
        end
        S_WB: begin
          if (rd_q) begin
            if (!d_q) begin
              w_out <= res_q;
            end
            flag_z <= (res_q == 8'h00);
            if (upd_c_q) begin
              flag_c <= carry_q;
            end
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (accept) begin
        op_q    <= instr_word[OP_MSB:OP_LSB];
        bit_q   <= instr_word[BIT_MSB:BIT_LSB];
        d_q     <= instr_word[D_POS];
        addr_q  <= instr_word[ADDR_MSB:ADDR_LSB];
        rd_q    <= dec_needs_read;
        upd_c_q <= dec_updates_carry;
        if (dec_is_nop || dec_illegal) begin
          state <= S_WB;
          done  <= 1'b1;
          err   <= dec_illegal;
        end else begin
          state <= S_READ;
          rf_re <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: instr_valid in 1, instr_ready out 1, instr_word in 16; fields [15:12] op, [11:9] bit_number, [8] d (0=W, 1=file), [7:0] file address.
REQ-004 SHALL have register-file ports: rf_addr out 8, rf_re out 1, rf_rdata in 8 (valid the cycle after rf_re), rf_we out 1, rf_wdata out 8.
REQ-005 SHALL have ALU ports: alu_op out 4, alu_bit out 3, alu_a out 8 (W), alu_b out 8 (file operand), alu_result in 8, alu_carry in 1.
REQ-006 SHALL have status ports: w_out out 8, flag_z out 1, flag_c out 1, busy out 1, done out 1 (one-cycle pulse), err out 1 (one-cycle pulse).

Function
REQ-007 SHALL implement FSM states IDLE, READ, EXEC, WB.
REQ-008 IDLE: instr_ready=1; on instr_valid&&instr_ready, latch instr_word; go to READ, or to WB for op 1000 (nop) and op 1111 (illegal).
REQ-009 READ: rf_re=1, rf_addr=latched address; next state EXEC.
REQ-010 EXEC: capture rf_rdata into operand register; alu_b is driven from it combinationally; alu_result/alu_carry sampled at end of EXEC; next state WB.
REQ-011 WB: d=0 writes result to W; d=1 asserts rf_we for one cycle with rf_addr=address, rf_wdata=result; done=1; next state IDLE.
REQ-012 alu_a SHALL always equal W; alu_op/alu_bit SHALL equal latched fields from READ through WB, and drive op 1000 while IDLE.
REQ-013 flag_z SHALL update to (result==0) in WB for every op except nop and illegal.
REQ-014 flag_c SHALL update from alu_carry only for ops 0010 (add), 0011 (sub), 0101 (inc), 0110 (dec); otherwise hold.
REQ-015 Nop: no rf_re, no rf_we, W and flags held, done pulses in WB; illegal op: same plus err=1 in WB.
REQ-016 Latency (no config): accept at cycle 0, done at cycle 3, instr_ready high again at cycle 4; nop done at cycle 1.
REQ-017 busy SHALL equal (state != IDLE); instr_word changes while busy SHALL be ignored.
REQ-018 All 8-bit arithmetic is performed by the external ALU; the block performs no arithmetic beyond the zero compare.

Reset
REQ-019 Reset assertion SHALL immediately force IDLE, W=0x00, flag_z=0, flag_c=0, rf_re=0, rf_we=0, done=0, err=0, instr_ready=1 after release.
REQ-020 Reset during READ/EXEC/WB SHALL abort the instruction with no register-file write and no done pulse.

Configuration
REQ-021 With ALU_SEQ_OVERLAP_EN defined, instr_ready SHALL also be 1 in WB, and an instruction accepted in WB SHALL enter READ the next cycle (3-cycle throughput); the write in WB completes before that READ.
REQ-022 Without ALU_SEQ_OVERLAP_EN, instr_ready SHALL be 1 only in IDLE (4-cycle throughput).

Structure
REQ-023 Package alu_seq_pkg SHALL hold the opcode enum (4 bits), the state enum, and instr_word field position constants.
REQ-024 Sub-module alu_seq_decode (combinational) SHALL produce needs_read, updates_carry, is_nop and illegal from op.

Verification
REQ-025 rf[0x10]=0x3C; op 0000 d=0 addr 0x10 -> rf_re at cycle 1, W=0x3C, Z=0, done at cycle 3, no rf_we.
REQ-026 W=0x3C, rf[0x11]=0xD0; op 0010 d=1 addr 0x11, ALU returns 0x0C carry=1 -> rf_we addr 0x11 data 0x0C, C=1, Z=0.
REQ-027 rf[0x12]=0x00, C=1; op 1101 bit 7 d=1 addr 0x12 -> write 0x80, Z=0, C stays 1.
REQ-028 Op 1000 then op 1111 -> each done at cycle 1, err only on 1111, no rf_re/rf_we, W and flags unchanged.
REQ-029 Reset asserted during EXEC of a d=1 add -> rf_we never asserted, W=0x00, flags 0, instr_ready=1 after release.
REQ-030 Back-to-back valid instructions with and without ALU_SEQ_OVERLAP_EN -> done pulses 3 cycles and 4 cycles apart respectively.
